dm_responder: RTL
=================

# dm_responder

Data-memory responder for the pipeline CPU's MEM stage. It accepts one load/store request at a time over a valid/ready handshake and models a memory with programmable wait states. It returns one response per request (read data or write acknowledge, plus an error flag), also over a valid/ready handshake. Storage is byte-addressed and big-endian, 32-bit word access only.

## Interface
Parameters:
- DEPTH_WORDS, 64: number of 32-bit words stored; byte address range is 0 to 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 2: wait states between request acceptance and access commit; legal range 0 to 15.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  requester has a request.
- req_ready  out  1  responder can accept; high only in IDLE with rst low.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  requester consumes the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  misaligned (req_addr[1:0]≠0) or out-of-range (req_addr ≥ 4*DEPTH_WORDS).

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE**
  - req_ready=1.
  - Request accepted when req_valid&&req_ready at a clock edge; latch we/addr/wdata.
  - If WAIT_CYCLES=0, go to RESP and commit at that same edge.
  - Otherwise load cnt=WAIT_CYCLES and go to WAIT.
- **WAIT**
  - Decrement cnt each cycle.
  - At the edge where cnt=1: commit the access and go to RESP.
- **Commit**
  - Load: rsp_rdata = {mem[a], mem[a+1], mem[a+2], mem[a+3]}, big-endian, with a = latched addr.
  - Store: write wdata[31:24] to mem[a] through wdata[7:0] to mem[a+3]; rsp_rdata=0.
  - Error: no memory access, rsp_err=1, rsp_rdata=0.
- **RESP**
  - rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_valid&&rsp_ready.
  - On the response handshake edge, go to IDLE and clear rsp_valid/rsp_rdata/rsp_err.
- req_* inputs are ignored outside IDLE; req_ready=0 in WAIT and RESP.
- Memory contents are not changed by rst and are undefined at power-up.
- Error check uses the full 32-bit address; no wrap-around (4*DEPTH_WORDS maps to error, not word 0).

## Timing
- Reset values: req_ready=0 while rst=1, then 1 in the first cycle after release; rsp_valid=0, rsp_rdata=0, rsp_err=0; state=IDLE; cnt=0.
- Latency: request accepted at edge k → rsp_valid high after edge k+WAIT_CYCLES+1.
- Throughput: with rsp_ready held high, one transaction per WAIT_CYCLES+2 cycles. IDLE always lasts at least one cycle between transactions.
- All outputs are registered except req_ready, which decodes state and rst.
- rst has priority over every event at the same edge.
- rst asserted in WAIT: transaction aborted, no store committed.
- rst asserted at the commit edge: store not performed.
- rst asserted in RESP: the store has already committed; the response is dropped.
- rsp_ready high in IDLE/WAIT has no effect.
- req_valid held high through RESP is not accepted until the cycle after the response handshake.

## Structure
- Package dm_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - width constants for data (32) and counter (4);
  - the helper function addr_err(addr, depth).
- Sub-module dm_storage: byte array of 4*DEPTH_WORDS entries, with a synchronous big-endian word write port and a combinational big-endian word read port.
- dm_responder contains only the FSM, counter, request latch, error check and response registers.

## Test plan
- Reset behaviour: assert rst 3 cycles, release → req_ready=0 during rst, req_ready=1 next cycle, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Store/load round trip, WAIT_CYCLES=2:
  - store addr 0x10, data 0xDEADBEEF → rsp_valid exactly 3 cycles after acceptance, rsp_err=0, rsp_rdata=0;
  - load addr 0x10 → rsp_rdata=0xDEADBEEF;
  - bytes at 0x10..0x13 = DE,AD,BE,EF.
- Errors:
  - load addr 0x12 → rsp_err=1, rsp_rdata=0;
  - store addr 0x100 with DEPTH_WORDS=64 → rsp_err=1, word 0 unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid/rsp_rdata stable; req_ready=0 with req_valid=1 held; request accepted only after the handshake plus one IDLE cycle.
- Reset mid-operation: store 0x55AA55AA to 0x20 (pre-loaded 0x11111111), assert rst in WAIT → load 0x20 returns 0x11111111.
- Zero wait, WAIT_CYCLES=0: back-to-back loads with rsp_ready=1 → rsp_valid 1 cycle after each acceptance; one transaction every 2 cycles.

Source files
------------

// File: rtl/dm_pkg.sv
// dm_pkg: shared state encoding, widths and address check for the data-memory responder
package dm_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int DATA_W = 32;
  localparam int CNT_W = 4;
  // Full 32-bit compare so addresses past the end never alias back onto word 0.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr} >= ({2'b00, depth} << 2));
  endfunction
endpackage

// File: rtl/dm_storage.sv
// dm_storage: big-endian byte array, synchronous word write, combinational word read
// ports: clk; i_we write strobe; i_addr byte address; i_wdata store word; o_rdata load word
module dm_storage import dm_pkg::*; #(
  parameter int DEPTH_WORDS = 64,
  localparam int AW = $clog2(4 * DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [7:0] r_mem [4*DEPTH_WORDS];
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr]           <= i_wdata[31:24];
      r_mem[i_addr + AW'(1)]  <= i_wdata[23:16];
      r_mem[i_addr + AW'(2)]  <= i_wdata[15:8];
      r_mem[i_addr + AW'(3)]  <= i_wdata[7:0];
    end
  end
  assign o_rdata = {r_mem[i_addr], r_mem[i_addr + AW'(1)], r_mem[i_addr + AW'(2)], r_mem[i_addr + AW'(3)]};
endmodule

// File: rtl/dm_responder.sv
// dm_responder: one-at-a-time load/store responder with programmable wait states
// ports: clk, rst; req_valid/req_ready/req_we/req_addr/req_wdata request side;
// rsp_valid/rsp_ready/rsp_rdata/rsp_err response side
module dm_responder import dm_pkg::*; #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int AW = $clog2(4 * DEPTH_WORDS);
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              r_rsp_valid;
  logic              w_commit;
  logic              w_we;
  logic              w_err;
  logic [31:0]       w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rd;
  // With zero wait states the access commits at the acceptance edge, so it must use the live request.
  assign w_we     = (r_state == IDLE) ? req_we : r_we;
  assign w_addr   = (r_state == IDLE) ? req_addr : r_addr;
  assign w_wdata  = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_err    = addr_err(w_addr, DEPTH_WORDS);
  assign w_commit = (WAIT_CYCLES == 0) ? (r_state == IDLE && req_valid) : (r_state == WAIT && r_cnt == CNT_W'(1));
  assign req_ready = (r_state == IDLE) && !rst;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  dm_storage #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
    .clk     (clk),
    .i_we    (w_commit && w_we && !w_err && !rst),
    .i_addr  (w_addr[AW-1:0]),
    .i_wdata (w_wdata),
    .o_rdata (w_rd)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_we    <= req_we;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_cnt   <= CNT_W'(WAIT_CYCLES);
          r_state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) r_state <= RESP;
        end
        RESP: if (rsp_ready) begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_rdata     <= '0;
          r_err       <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
      if (w_commit) begin
        r_rsp_valid <= 1'b1;
        r_err       <= w_err;
        r_rdata     <= (w_we || w_err) ? '0 : w_rd;
      end
    end
  end
endmodule
